// File: rtl/rs_constants.sv
// Shared constants for the reservation-station scheduler.
// FU indices, load/store opcodes and default FU latencies.
package rs_constants;

  localparam int NUM_FU = 3;

  localparam logic [1:0] FU_ALU0 = 2'd0;
  localparam logic [1:0] FU_ALU1 = 2'd1;
  localparam logic [1:0] FU_MEM  = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int ALU_LAT_DEF = 1;
  localparam int MEM_LAT_DEF = 3;

  function automatic logic is_mem_op(
    input logic [6:0] op
  );
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/fu_timer.sv
// Occupancy timer for one functional unit.
// Tracks busy cycles, the in-flight ROB tag and the completion pulse.
module fu_timer
  import rs_constants::*;
#(
  parameter int ROB_WIDTH = 6,
  parameter int LAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 grant,
  input  logic [ROB_WIDTH-1:0] rob,
  output logic                 ready,
  output logic                 cplt_valid,
  output logic [ROB_WIDTH-1:0] cplt_rob
);

  localparam logic [2:0] LAT3 = 3'(LAT);

  logic [2:0]           cnt;
  logic [ROB_WIDTH-1:0] tag;
  logic                 done;

  // Last busy cycle ends on this edge unless frozen.
  assign done  = (cnt == 3'd1) && !stall;

  // Free now, or freeing on this edge.
  assign ready = (cnt == 3'd0) || done;

  // Counter, tag and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 3'd0;
      tag        <= '0;
      cplt_valid <= 1'b0;
      cplt_rob   <= '0;
    end else if (flush) begin
      cnt        <= 3'd0;
      cplt_valid <= 1'b0;
    end else begin
      cplt_valid <= done;
      if (done) begin
        cplt_rob <= tag;
      end
      if (grant) begin
        cnt <= LAT3;
        tag <= rob;
      end else if ((cnt != 3'd0) && !stall) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: rtl/fu_scheduler.sv
// FU scheduler: dispatch assignment, issue grants, FU occupancy.
// Memory ops go to MEM; other ops alternate between ALU0 and ALU1.
module fu_scheduler
  import rs_constants::*;
#(
  parameter int ROB_WIDTH = 6,
  parameter int ALU_LAT   = ALU_LAT_DEF,
  parameter int MEM_LAT   = MEM_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   disp_valid,
  input  logic                   disp_is_mem,
  output logic [1:0]             disp_fu,
  input  logic [2:0]             issue_req,
  input  logic [3*ROB_WIDTH-1:0] issue_rob,
  input  logic                   mem_stall,
  output logic [2:0]             issue_grant,
  output logic [2:0]             fu_ready,
  output logic [2:0]             complete_valid,
  output logic [3*ROB_WIDTH-1:0] complete_rob
);

  logic       next_alu;
  logic [2:0] raw_ready;
  logic [2:0] stall_vec;

  assign stall_vec   = {mem_stall, 2'b00};
  assign fu_ready    = flush ? 3'b000 : raw_ready;
  assign issue_grant = issue_req & fu_ready;

  // Pick the FU for the op being dispatched.
  always_comb begin
    disp_fu = FU_ALU0;
    unique case (1'b1)
      disp_is_mem:              disp_fu = FU_MEM;
      !disp_is_mem && next_alu: disp_fu = FU_ALU1;
      default:                  disp_fu = FU_ALU0;
    endcase
  end

  // Round-robin ALU pointer advances on each non-mem dispatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_alu <= 1'b0;
    end else if (disp_valid && !disp_is_mem) begin
      next_alu <= !next_alu;
    end
  end

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
    fu_timer #(
      .ROB_WIDTH(ROB_WIDTH),
      .LAT      ((k == 2) ? MEM_LAT : ALU_LAT)
    ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .stall     (stall_vec[k]),
      .grant     (issue_grant[k]),
      .rob       (issue_rob[k*ROB_WIDTH +: ROB_WIDTH]),
      .ready     (raw_ready[k]),
      .cplt_valid(complete_valid[k]),
      .cplt_rob  (complete_rob[k*ROB_WIDTH +: ROB_WIDTH])
    );
  end

endmodule

// File: tb/tb_fu_scheduler.sv
// Scoreboard bench for fu_scheduler.
// Stimulus queues expected completions; a monitor pops and compares.
module tb_fu_scheduler;
  import rs_constants::*;

  localparam int RW      = 6;
  localparam int ALU_LAT = 1;
  localparam int MEM_LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          disp_valid = 1'b0;
  logic          disp_is_mem = 1'b0;
  logic [1:0]    disp_fu;
  logic [2:0]    issue_req = 3'b000;
  logic [3*RW-1:0] issue_rob = '0;
  logic          mem_stall = 1'b0;
  logic [2:0]    issue_grant;
  logic [2:0]    fu_ready;
  logic [2:0]    complete_valid;
  logic [3*RW-1:0] complete_rob;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int fu;
    int rob;
    int cyc;
  } exp_t;

  exp_t sb[$];

  fu_scheduler #(
    .ROB_WIDTH(RW),
    .ALU_LAT  (ALU_LAT),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_is_mem   (disp_is_mem),
    .disp_fu       (disp_fu),
    .issue_req     (issue_req),
    .issue_rob     (issue_rob),
    .mem_stall     (mem_stall),
    .issue_grant   (issue_grant),
    .fu_ready      (fu_ready),
    .complete_valid(complete_valid),
    .complete_rob  (complete_rob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic set_rob(input int k, input int v);
    issue_rob[k*RW +: RW] = RW'(v);
  endtask

  task automatic push(input int fu, input int rob, input int lat);
    exp_t e;
    e.fu  = fu;
    e.rob = rob;
    e.cyc = cyc + lat + 1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (complete_valid[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].fu == k) idx = i;
          if (idx < 0) begin
            total_cnt++;
            $display("FAIL unexpected_cplt fu%0d: got rob %0d at cycle %0d, expected none",
                     k, complete_rob[k*RW +: RW], cyc);
          end else begin
            check($sformatf("cplt_rob fu%0d", k),
                  int'(complete_rob[k*RW +: RW]), sb[idx].rob);
            check($sformatf("cplt_cyc fu%0d", k), cyc, sb[idx].cyc);
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    disp_valid = 1'b1;
    probe();
    check("reset_ready", int'(fu_ready), 7);
    check("reset_cv", int'(complete_valid), 0);
    check("reset_disp_fu", int'(disp_fu), 0);
    disp_valid = 1'b0;

    step();
    disp_valid = 1'b1;
    probe(); check("disp0", int'(disp_fu), 0);
    step();  probe(); check("disp1", int'(disp_fu), 1);
    step();  probe(); check("disp2", int'(disp_fu), 0);
    step();
    disp_is_mem = 1'b1;
    probe(); check("disp_mem", int'(disp_fu), 2);
    step();
    disp_is_mem = 1'b0;
    probe(); check("next_alu_after", int'(disp_fu), 1);
    disp_valid = 1'b0;

    step();
    issue_req = 3'b001;
    set_rob(0, 5);
    probe(); check("alu_grant_a", int'(issue_grant), 1);
    push(0, 5, ALU_LAT);
    step();
    set_rob(0, 6);
    probe();
    check("alu_grant_b", int'(issue_grant), 1);
    check("alu_ready_b2b", int'(fu_ready[0]), 1);
    push(0, 6, ALU_LAT);
    step();
    issue_req = 3'b000;
    repeat (4) step();

    issue_req = 3'b100;
    set_rob(2, 9);
    probe(); check("mem_grant", int'(issue_grant), 4);
    push(2, 9, MEM_LAT + 2);
    step();
    issue_req = 3'b000;
    probe(); check("mem_busy1", int'(fu_ready[2]), 0);
    step();
    mem_stall = 1'b1;
    probe(); check("mem_busy2", int'(fu_ready[2]), 0);
    step();
    probe(); check("mem_busy3", int'(fu_ready[2]), 0);
    step();
    mem_stall = 1'b0;
    probe(); check("mem_busy4", int'(fu_ready[2]), 0);
    step();
    probe(); check("mem_early_rel", int'(fu_ready[2]), 1);
    step();
    step();
    mem_stall = 1'b1;
    probe(); check("idle_stall_ready", int'(fu_ready), 7);
    step();
    mem_stall = 1'b0;
    repeat (2) step();

    issue_req = 3'b110;
    set_rob(1, 12);
    set_rob(2, 13);
    probe(); check("pre_flush_grant", int'(issue_grant), 6);
    step();
    flush = 1'b1;
    issue_req = 3'b111;
    probe();
    check("flush_grant", int'(issue_grant), 0);
    check("flush_ready", int'(fu_ready), 0);
    step();
    flush = 1'b0;
    issue_req = 3'b000;
    probe();
    check("post_flush_ready", int'(fu_ready), 7);
    check("post_flush_cv", int'(complete_valid), 0);
    repeat (5) step();
    probe(); check("flush_quiet_cv", int'(complete_valid), 0);

    step();
    issue_req = 3'b100;
    set_rob(2, 20);
    probe(); check("rst_mem_grant", int'(issue_grant), 4);
    step();
    issue_req = 3'b000;
    step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", int'(fu_ready), 7);
    check("async_rst_cv", int'(complete_valid), 0);
    #3 rst = 1'b0;
    repeat (6) step();
    disp_valid = 1'b1;
    probe(); check("rst_next_alu", int'(disp_fu), 0);
    disp_valid = 1'b0;
    step();

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fu_scheduler.md
# fu_scheduler

Functional-unit scheduler for the out-of-order core's reservation station. It assigns an FU to each dispatched instruction: memory ops go to MEM, other ops alternate between ALU0 and ALU1. It publishes the per-FU ready vector the reservation station uses for issue, grants issue requests, and times each FU's occupancy. It reports completions with the ROB number of the finishing instruction.

## Interface
- `ROB_WIDTH`, 6, ROB index width
- `ALU_LAT`, 1, ALU occupancy in cycles (1..7)
- `MEM_LAT`, 3, MEM occupancy in cycles before stall extension (1..7)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous squash of all in-flight FU work
- `disp_valid`  in  1  dispatch requests an FU assignment this cycle
- `disp_is_mem`  in  1  dispatched op is a load/store (opcode 0000011/0100011)
- `disp_fu`  out  2  assigned FU index (0=ALU0, 1=ALU1, 2=MEM), combinational
- `issue_req`  in  3  bit k: reservation station has a ready entry for FU k
- `issue_rob`  in  3*ROB_WIDTH  ROB number per request; slice k belongs to FU k
- `mem_stall`  in  1  memory not done; MEM occupancy frozen
- `issue_grant`  out  3  bit k: request k accepted this cycle, combinational
- `fu_ready`  out  3  bit k: FU k can accept an issue this cycle, combinational from state
- `complete_valid`  out  3  bit k: FU k finished, one-cycle registered pulse
- `complete_rob`  out  3*ROB_WIDTH  ROB number of finishing instruction, registered

## Operation
- Per FU k, keep a 3-bit counter `cnt[k]` and a ROB tag register `tag[k]`. Latency `LAT[k]` is ALU_LAT for k=0,1 and MEM_LAT for k=2.
- `stall[k]` is `mem_stall` for k=2 and 0 for k=0,1.
- `fu_ready[k] = !flush && (cnt[k]==0 || (cnt[k]==1 && !stall[k]))`. The early release at cnt==1 allows back-to-back issue.
- `issue_grant[k] = issue_req[k] & fu_ready[k]`.
- On a grant: `cnt[k] <= LAT[k]` and `tag[k] <= issue_rob slice k`.
- Otherwise, if `cnt[k]!=0 && !stall[k]`: `cnt[k] <= cnt[k]-1`.
- A transition of cnt[k] from 1 to 0, or a grant that replaces cnt==1, registers `complete_valid[k]<=1` and `complete_rob[k]<=tag[k]` (old tag). In every other cycle `complete_valid[k]<=0`.
- Completion and a new grant on the same edge are both honored: the old tag is reported and the new tag is loaded.
- Dispatch assignment:
  - `disp_fu = disp_is_mem ? 2 : {1'b0,next_alu}`.
  - `next_alu` toggles only on edges with `disp_valid && !disp_is_mem`.
  - If `!disp_valid`, disp_fu is don't-care and next_alu holds.
- Flush:
  - grants forced to 0 that cycle.
  - next edge: all cnt<=0 and all complete_valid<=0, so no completion pulses for squashed work.
  - next_alu is unaffected.
- mem_stall while cnt[2]==0 has no effect.
- Counter arithmetic is unsigned 3-bit and never wraps. The decrement is gated by cnt!=0.

## Timing
- Reset values: cnt=0, tag=0, next_alu=0, complete_valid=000, complete_rob=0. fu_ready=111 immediately after reset; issue_grant follows issue_req.
- Grant is combinational in the same cycle as the request. With no stall, completion pulses in cycle t+LAT+1 for a grant in cycle t.
- Example, ALU_LAT=1: grant in t, cnt=1 in t+1, fu_ready=1 again in t+1, complete_valid in t+2. Sustains one issue per cycle per ALU.
- Each cycle of mem_stall while cnt[2]!=0 adds exactly one cycle to MEM latency.
- rst asserted mid-operation clears all state asynchronously. In-flight completions are lost.

## Structure
- Shared package `rs_constants`: FU index constants FU_ALU0/FU_ALU1/FU_MEM, the load/store opcodes, and default ALU_LAT/MEM_LAT.
- One sub-module `fu_timer` (cnt, tag, stall, grant, completion pulse) instantiated three times. The top level holds next_alu, dispatch assignment and flush gating.

## Test plan
- Reset, then idle → fu_ready=111, complete_valid=000, disp_fu=0 for a non-mem dispatch.
- Three non-mem dispatches followed by one mem dispatch → disp_fu sequence 0,1,0,2. next_alu=1 afterwards.
- issue_req=001 with rob 5 at cycle t, then rob 6 at t+1 (ALU_LAT=1) → grants in t and t+1, complete_valid[0] at t+2 (rob 5) and at t+3 (rob 6).
- MEM grant rob 9 with mem_stall high for 2 cycles mid-flight (MEM_LAT=3) → fu_ready[2]=0 throughout, completion at t+6 with rob 9.
- MEM busy and ALU1 busy, assert flush for one cycle with issue_req=111 → grant=000, no completion pulses afterwards, fu_ready=111 next cycle.
- Assert rst asynchronously mid-clock with cnt[2]=2 → fu_ready=111 and complete_valid=000 before the next edge.
